// File: rtl/ac_sum_serializer_if.sv
// rtl/ac_sum_serializer_if.sv - byte stream interface carrying serialized accumulator samples
//
// Purpose: groups the valid/ready byte stream produced by ac_sum_serializer.
// Signals:
//   out_byte   8  serialized byte (MSB byte of a sample first)
//   out_valid  1  out_byte is valid
//   out_ready  1  consumer accepts the byte
//   out_last   1  high with the LSB (second) byte of a sample
// Modports:
//   master  - the serializer (drives byte/valid/last, samples ready)
//   slave   - the consumer
interface ac_sum_serializer_if;
  logic [7:0] out_byte;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport master (
    output out_byte,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_byte,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/ac_sum_serializer.sv
// rtl/ac_sum_serializer.sv - snapshots the accumulator sum into a FIFO and streams it out as bytes
//
// Purpose: on cap, pushes the 16-bit accumulator sum into a DEPTH-entry FIFO;
// a three-state serializer then emits each entry as two bytes, MSB first,
// over a valid/ready byte stream without ever stalling the accumulator.
// Optional feature macro: AC_SER_WRAP_DET_EN (wrap-around detector on sum).
//
// Parameters:
//   DEPTH     FIFO entries of 16 bits; power of 2, minimum 2.
// Ports:
//   clk       in   1   single clock, posedge
//   rst       in   1   synchronous active-high reset
//   sum       in   16  accumulator output, sampled directly
//   cap       in   1   capture strobe, pushes sum into the FIFO
//   ob        master  byte stream (out_byte/out_valid/out_ready/out_last)
//   full      out  1   FIFO holds DEPTH entries
//   empty     out  1   FIFO holds 0 entries
//   drop_cnt  out  8   saturating count of captures lost to a full FIFO
//   wrap      out  1   one-cycle pulse when sum decreases (0 unless
//                      AC_SER_WRAP_DET_EN is defined)
module ac_sum_serializer #(
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [15:0]                 sum,
  input  logic                        cap,
  ac_sum_serializer_if.master         ob,
  output logic                        full,
  output logic                        empty,
  output logic [7:0]                  drop_cnt,
  output logic                        wrap
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  // ---------------------------------------------------------------------
  // FIFO storage and bookkeeping
  // ---------------------------------------------------------------------
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    drop_q;

  logic          push;
  logic          pop;

  // Flags come from the registered count, so a pop in the same cycle cannot
  // make room for a capture that arrives while full.
  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);

  assign push = cap & ~full;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers are AW bits wide, so +1 wraps modulo DEPTH for free.
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= '0;
    end else if (cap && full && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  assign drop_cnt = drop_q;

  // ---------------------------------------------------------------------
  // Serializer FSM
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] hold_q,  hold_d;
  logic [7:0]  byte_q,  byte_d;
  logic        valid_q, valid_d;
  logic        last_q,  last_d;

  logic        xfer;
  logic        load;
  logic [15:0] head;

  assign xfer = valid_q & ob.out_ready;
  assign head = mem[rd_ptr];
  assign pop  = load;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    byte_d  = byte_q;
    valid_d = valid_q;
    last_d  = last_q;
    load    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!empty) begin
          load = 1'b1;
        end
      end
      HI: begin
        if (xfer) begin
          state_d = LO;
          byte_d  = hold_q[7:0];
          last_d  = 1'b1;
        end
      end
      LO: begin
        if (xfer) begin
          if (!empty) begin
            // Chain straight into the next sample so the stream has no bubble.
            load = 1'b1;
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            byte_d  = 8'h00;
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
        byte_d  = 8'h00;
      end
    endcase

    // The output byte is registered alongside the state, so it is loaded
    // directly from the FIFO head rather than from the holding register.
    if (load) begin
      state_d = HI;
      hold_d  = head;
      byte_d  = head[15:8];
      valid_d = 1'b1;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign ob.out_byte  = byte_q;
  assign ob.out_valid = valid_q;
  assign ob.out_last  = last_q;

  // ---------------------------------------------------------------------
  // Optional wrap-around detector
  // ---------------------------------------------------------------------
`ifdef AC_SER_WRAP_DET_EN
  logic [15:0] prev_sum;
  logic        prev_valid;
  logic        wrap_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_sum   <= '0;
      prev_valid <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      prev_sum   <= sum;
      prev_valid <= 1'b1;
      // A decreasing running total can only mean the accumulator wrapped.
      wrap_q     <= prev_valid && (sum < prev_sum);
    end
  end

  assign wrap = wrap_q;
`else
  assign wrap = 1'b0;
`endif

endmodule

// File: tb/tb_ac_sum_serializer.sv
// tb/tb_ac_sum_serializer.sv - self-checking bench for ac_sum_serializer
module tb_ac_sum_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sum = 16'h0000;
  logic        cap = 1'b0;
  logic        full;
  logic        empty;
  logic [7:0]  drop_cnt;
  logic        wrap;

  int checks   = 0;
  int failures = 0;

  ac_sum_serializer_if ob ();

  ac_sum_serializer #(.DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .sum      (sum),
    .cap      (cap),
    .ob       (ob.master),
    .full     (full),
    .empty    (empty),
    .drop_cnt (drop_cnt),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] s;
    int          stall;
    logic [7:0]  hi;
    logic [7:0]  lo;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cap = 1'b0;
    ob.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Wait (bounded) for a valid byte, then let it transfer with ready high.
  task automatic recv(output logic [7:0] b, output logic l);
    int n;
    n = 0;
    ob.out_ready = 1'b1;
    while (!ob.out_valid && n < 20) begin
      tick();
      n++;
    end
    if (!ob.out_valid) begin
      chk("recv_timeout", 32'(ob.out_valid), 32'd1);
    end
    b = ob.out_byte;
    l = ob.out_last;
    tick();
  endtask

  logic [7:0]  rb;
  logic        rl;
  logic [7:0]  b2b_exp [6];

  initial begin
    vecs[0] = '{s: 16'h1234, stall: 0, hi: 8'h12, lo: 8'h34};
    vecs[1] = '{s: 16'hABCD, stall: 5, hi: 8'hAB, lo: 8'hCD};
    vecs[2] = '{s: 16'h0000, stall: 1, hi: 8'h00, lo: 8'h00};
    vecs[3] = '{s: 16'hFFFF, stall: 2, hi: 8'hFF, lo: 8'hFF};
    vecs[4] = '{s: 16'h8001, stall: 3, hi: 8'h80, lo: 8'h01};

    ob.out_ready = 1'b0;
    do_reset();

    // Reset values
    chk("rst_out_byte",  32'(ob.out_byte),  32'h00);
    chk("rst_out_valid", 32'(ob.out_valid), 32'd0);
    chk("rst_out_last",  32'(ob.out_last),  32'd0);
    chk("rst_full",      32'(full),         32'd0);
    chk("rst_empty",     32'(empty),        32'd1);
    chk("rst_drop_cnt",  32'(drop_cnt),     32'd0);
    chk("rst_wrap",      32'(wrap),         32'd0);

    // Table-driven single samples with optional back-pressure
    for (int v = 0; v < 5; v++) begin
      ob.out_ready = 1'b0;
      sum = vecs[v].s;
      cap = 1'b1;
      tick();
      cap = 1'b0;
      chk("lat_empty_after_cap", 32'(empty), 32'd0);
      chk("lat_valid_low",       32'(ob.out_valid), 32'd0);
      tick();
      chk("hi_valid", 32'(ob.out_valid), 32'd1);
      chk("hi_byte",  32'(ob.out_byte),  32'(vecs[v].hi));
      chk("hi_last",  32'(ob.out_last),  32'd0);
      for (int k = 0; k < vecs[v].stall; k++) begin
        tick();
        chk("stall_valid", 32'(ob.out_valid), 32'd1);
        chk("stall_byte",  32'(ob.out_byte),  32'(vecs[v].hi));
      end
      ob.out_ready = 1'b1;
      tick();
      chk("lo_valid", 32'(ob.out_valid), 32'd1);
      chk("lo_byte",  32'(ob.out_byte),  32'(vecs[v].lo));
      chk("lo_last",  32'(ob.out_last),  32'd1);
      tick();
      chk("done_valid", 32'(ob.out_valid), 32'd0);
      chk("done_empty", 32'(empty),        32'd1);
      ob.out_ready = 1'b0;
    end

    // Overflow: 6 captures, one absorbed by the serializer, one dropped
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      sum = 16'(i);
      cap = 1'b1;
      tick();
      chk("ovf_full", 32'(full), (i >= 5) ? 32'd1 : 32'd0);
    end
    cap = 1'b0;
    chk("ovf_drop_cnt", 32'(drop_cnt), 32'd1);
    for (int i = 1; i <= 5; i++) begin
      recv(rb, rl);
      chk("ovf_hi", 32'(rb), 32'h00);
      chk("ovf_hi_last", 32'(rl), 32'd0);
      recv(rb, rl);
      chk("ovf_lo", 32'(rb), 32'(i));
      chk("ovf_lo_last", 32'(rl), 32'd1);
    end
    tick();
    chk("ovf_end_valid", 32'(ob.out_valid), 32'd0);
    chk("ovf_end_empty", 32'(empty), 32'd1);

    // Back-to-back: three queued samples stream with no idle cycle
    do_reset();
    sum = 16'h1122; cap = 1'b1; tick();
    sum = 16'h3344; tick();
    sum = 16'h5566; tick();
    cap = 1'b0;
    b2b_exp[0] = 8'h11; b2b_exp[1] = 8'h22; b2b_exp[2] = 8'h33;
    b2b_exp[3] = 8'h44; b2b_exp[4] = 8'h55; b2b_exp[5] = 8'h66;
    ob.out_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      chk("b2b_valid", 32'(ob.out_valid), 32'd1);
      chk("b2b_byte",  32'(ob.out_byte),  32'(b2b_exp[j]));
      chk("b2b_last",  32'(ob.out_last),  32'(j % 2));
      tick();
    end
    chk("b2b_end_valid", 32'(ob.out_valid), 32'd0);
    ob.out_ready = 1'b0;

    // Drop counter saturation: 5 captures fill the pipe, then drops
    do_reset();
    sum = 16'hC3C3;
    cap = 1'b1;
    for (int i = 0; i < 5 + 254; i++) tick();
    chk("sat_254", 32'(drop_cnt), 32'd254);
    tick();
    chk("sat_255", 32'(drop_cnt), 32'd255);
    for (int i = 0; i < 45; i++) tick();
    chk("sat_hold", 32'(drop_cnt), 32'd255);
    cap = 1'b0;

    // Reset mid-stream: MSB transfers, then reset kills the LSB
    chk("mid_hi_valid", 32'(ob.out_valid), 32'd1);
    chk("mid_hi_byte",  32'(ob.out_byte),  32'hC3);
    ob.out_ready = 1'b1;
    tick();
    chk("mid_lo_last", 32'(ob.out_last), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(ob.out_valid), 32'd0);
    chk("mid_rst_empty", 32'(empty),        32'd1);
    chk("mid_rst_drop",  32'(drop_cnt),     32'd0);
    chk("mid_rst_full",  32'(full),         32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mid_no_lsb", 32'(ob.out_valid), 32'd0);
    end
    ob.out_ready = 1'b0;

    // Wrap detection
    do_reset();
    sum = 16'hFFF0;
    tick();
    tick();
    chk("wrap_pre", 32'(wrap), 32'd0);
    sum = 16'h0005;
    tick();
`ifdef AC_SER_WRAP_DET_EN
    chk("wrap_pulse", 32'(wrap), 32'd1);
`else
    chk("wrap_off", 32'(wrap), 32'd0);
`endif
    tick();
    chk("wrap_after", 32'(wrap), 32'd0);
    sum = 16'h0006;
    tick();
    chk("wrap_rising", 32'(wrap), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
